// File: rtl/scan_pkg.sv
// Shared types and constants for the digit scan sequencer and its display store.
package scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam int CODE_W     = 4;
    localparam int MAX_DIGITS = 8;

endpackage

// File: rtl/digit_buffer.sv
// Double-buffered 8x4 digit store: writes land in the shadow copy, and a commit
// copies the whole shadow into the active copy that feeds the display.
module digit_buffer
    import scan_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [2:0]        i_wr_addr,
    input  logic [CODE_W-1:0] i_wr_data,
    input  logic              i_commit,
    input  logic [2:0]        i_rd_sel,
    output logic [CODE_W-1:0] o_rd_data
);

    logic [CODE_W-1:0] r_shadow [MAX_DIGITS];
    logic [CODE_W-1:0] r_active [MAX_DIGITS];
    logic              w_wr_ok;

    // Qualify the write strobe against the configured digit count.
    always_comb begin
        w_wr_ok = 1'b0;
        if (i_wr_en && ({1'b0, i_wr_addr} < 4'(DIGITS))) begin
            w_wr_ok = 1'b1;
        end else begin
            w_wr_ok = 1'b0;
        end
    end

    // Shadow store write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_DIGITS; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_shadow[i_wr_addr] <= i_wr_data;
        end
    end

    // Commit copies pre-edge shadow contents, so a same-edge write waits a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_DIGITS; i++) begin
                r_active[i] <= '0;
            end
        end else if (i_commit) begin
            for (int i = 0; i < MAX_DIGITS; i++) begin
                r_active[i] <= r_shadow[i];
            end
        end
    end

    assign o_rd_data = r_active[i_rd_sel];

endmodule

// File: rtl/scan_sequencer.sv
// Time-multiplexed digit scan controller driving a 3-to-8 decoder: per slot a
// short blanking window, then the selected digit is lit until the slot ends.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DIV    = 1000,
    parameter int BLANK  = 16,
    parameter int DIGITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [CODE_W-1:0] wr_data,
    output logic              A2,
    output logic              A1,
    output logic              A0,
    output logic              dec_en,
    output logic [CODE_W-1:0] digit_data,
    output logic              frame_done
);

    localparam int             CNT_W         = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE     = CNT_W'(DIV - 2);
    localparam logic [CNT_W-1:0] CNT_BLK_END = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [2:0]       SEL_LAST    = 3'(DIGITS - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_sel;
    logic             r_dec_en;
    logic             r_frame_done;
    logic             w_last_digit;
    logic             w_commit;

    // Commit on scan start and on the edge that wraps the select back to 0.
    always_comb begin
        w_last_digit = (r_sel == SEL_LAST);
        w_commit     = 1'b0;
        if (en) begin
            case (r_state)
                ST_IDLE: w_commit = 1'b1;
                ST_SHOW: w_commit = (r_cnt == CNT_LAST) && w_last_digit;
                default: w_commit = 1'b0;
            endcase
        end else begin
            w_commit = 1'b0;
        end
    end

    // Scan FSM, slot counter and digit select; frame_done is raised one edge
    // early so it is high exactly during the final lit cycle of the last digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_sel        <= 3'd0;
            r_dec_en     <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (!en) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_sel        <= 3'd0;
            r_dec_en     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_state  <= ST_BLANK;
                    r_cnt    <= '0;
                    r_sel    <= 3'd0;
                    r_dec_en <= 1'b0;
                end
                ST_BLANK: begin
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_BLK_END) begin
                        r_state      <= ST_SHOW;
                        r_dec_en     <= 1'b1;
                        r_frame_done <= (CNT_BLK_END == CNT_PRE) && w_last_digit;
                    end else begin
                        r_dec_en <= 1'b0;
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state  <= ST_BLANK;
                        r_cnt    <= '0;
                        r_dec_en <= 1'b0;
                        r_sel    <= w_last_digit ? 3'd0 : (r_sel + 3'd1);
                    end else begin
                        r_cnt        <= r_cnt + CNT_ONE;
                        r_dec_en     <= 1'b1;
                        r_frame_done <= (r_cnt == CNT_PRE) && w_last_digit;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_cnt    <= '0;
                    r_sel    <= 3'd0;
                    r_dec_en <= 1'b0;
                end
            endcase
        end
    end

    digit_buffer #(
        .DIGITS (DIGITS)
    ) u_digit_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_commit  (w_commit),
        .i_rd_sel  (r_sel),
        .o_rd_data (digit_data)
    );

    assign {A2, A1, A0} = r_sel;
    assign dec_en       = r_dec_en;
    assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed self-checking bench for scan_sequencer with DIV=8, BLANK=2, DIGITS=8.
module tb_scan_sequencer;

    localparam int DIV    = 8;
    localparam int BLANK  = 2;
    localparam int DIGITS = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [3:0] wr_data = 4'd0;
    logic       A2, A1, A0, dec_en, frame_done;
    logic [3:0] digit_data;

    int errors = 0;
    int checks = 0;
    int ph     = 0;
    int f_base = 0;

    scan_sequencer #(.DIV(DIV), .BLANK(BLANK), .DIGITS(DIGITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .A2         (A2),
        .A1         (A1),
        .A0         (A0),
        .dec_en     (dec_en),
        .digit_data (digit_data),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        ph++;
    endtask

    // Expected display code for frame f, slot s given the writes this bench makes.
    function automatic logic [3:0] exp_code(input int f, input int s);
        logic [3:0] c;
        c = 4'(s);
        if (f >= 3 && s == 1) c = 4'hF;
        if (f >= 3 && s == 6) c = 4'hE;
        if (f >= 5 && s == 0) c = 4'hA;
        return c;
    endfunction

    task automatic test_reset();
        logic [8:0] obs;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        obs = {A2, A1, A0, dec_en, digit_data, frame_done};
        checks++;
        if (obs !== 9'd0) begin
            errors++;
            $display("FAIL reset_hold outputs=%b expected=%b", obs, 9'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            obs = {A2, A1, A0, dec_en, digit_data, frame_done};
            checks++;
            if (obs !== 9'd0) begin
                errors++;
                $display("FAIL idle_after_reset cyc=%0d outputs=%b expected=%b", i, obs, 9'd0);
            end
        end
    endtask

    task automatic test_full_scan();
        int s, o;
        for (int a = 0; a < 8; a++) begin
            wr_en = 1'b1; wr_addr = 3'(a); wr_data = 4'(a);
            @(negedge clk);
        end
        wr_en = 1'b0;
        checks++;
        if (digit_data !== 4'd0) begin
            errors++;
            $display("FAIL shadow_not_visible digit_data=%h expected=%h", digit_data, 4'd0);
        end
        en = 1'b1;
        @(negedge clk);
        ph = 0; f_base = 0;
        while (ph < 128) begin
            s = (ph / 8) % 8; o = ph % 8;
            checks++;
            if (dec_en !== (o >= BLANK)) begin
                errors++;
                $display("FAIL scan_dec_en ph=%0d got=%b expected=%b", ph, dec_en, (o >= BLANK));
            end
            checks++;
            if ({A2, A1, A0} !== 3'(s)) begin
                errors++;
                $display("FAIL scan_sel ph=%0d got=%0d expected=%0d", ph, {A2, A1, A0}, s);
            end
            checks++;
            if (digit_data !== exp_code(f_base + ph / 64, s)) begin
                errors++;
                $display("FAIL scan_data ph=%0d got=%h expected=%h", ph, digit_data, exp_code(f_base + ph / 64, s));
            end
            checks++;
            if (frame_done !== (ph % 64 == 63)) begin
                errors++;
                $display("FAIL scan_frame_done ph=%0d got=%b expected=%b", ph, frame_done, (ph % 64 == 63));
            end
            tick();
        end
    endtask

    task automatic test_double_buffer();
        int s;
        while (ph < 255) begin
            s = (ph / 8) % 8;
            checks++;
            if ({A2, A1, A0} !== 3'(s)) begin
                errors++;
                $display("FAIL dbuf_sel ph=%0d got=%0d expected=%0d", ph, {A2, A1, A0}, s);
            end
            checks++;
            if (digit_data !== exp_code(f_base + ph / 64, s)) begin
                errors++;
                $display("FAIL dbuf_data ph=%0d got=%h expected=%h", ph, digit_data, exp_code(f_base + ph / 64, s));
            end
            if (ph == 152) begin
                wr_en = 1'b1; wr_addr = 3'd1; wr_data = 4'hF;
            end else if (ph == 153) begin
                wr_en = 1'b1; wr_addr = 3'd6; wr_data = 4'hE;
            end else begin
                wr_en = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_write_on_commit();
        int s;
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL commit_edge_frame_done ph=%0d got=%b expected=1", ph, frame_done);
        end
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'hA;
        tick();
        wr_en = 1'b0;
        while (ph < 384) begin
            s = (ph / 8) % 8;
            checks++;
            if (digit_data !== exp_code(f_base + ph / 64, s)) begin
                errors++;
                $display("FAIL commit_data ph=%0d got=%h expected=%h", ph, digit_data, exp_code(f_base + ph / 64, s));
            end
            checks++;
            if (frame_done !== (ph % 64 == 63)) begin
                errors++;
                $display("FAIL commit_frame_done ph=%0d got=%b expected=%b", ph, frame_done, (ph % 64 == 63));
            end
            tick();
        end
    endtask

    task automatic test_enable_drop();
        int s, o;
        while (ph < 428) tick();
        checks++;
        if ({A2, A1, A0, dec_en} !== {3'd5, 1'b1}) begin
            errors++;
            $display("FAIL drop_pre sel_en=%b expected=%b", {A2, A1, A0, dec_en}, {3'd5, 1'b1});
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({A2, A1, A0, dec_en, frame_done, digit_data} !== {3'd0, 1'b0, 1'b0, 4'hA}) begin
                errors++;
                $display("FAIL drop_idle cyc=%0d got=%b expected=%b", i,
                         {A2, A1, A0, dec_en, frame_done, digit_data}, {3'd0, 1'b0, 1'b0, 4'hA});
            end
        end
        en = 1'b1;
        tick();
        ph = 0; f_base = 6;
        while (ph < 64) begin
            s = (ph / 8) % 8; o = ph % 8;
            checks++;
            if (dec_en !== (o >= BLANK)) begin
                errors++;
                $display("FAIL restart_dec_en ph=%0d got=%b expected=%b", ph, dec_en, (o >= BLANK));
            end
            checks++;
            if ({A2, A1, A0} !== 3'(s)) begin
                errors++;
                $display("FAIL restart_sel ph=%0d got=%0d expected=%0d", ph, {A2, A1, A0}, s);
            end
            checks++;
            if (digit_data !== exp_code(f_base, s)) begin
                errors++;
                $display("FAIL restart_data ph=%0d got=%h expected=%h", ph, digit_data, exp_code(f_base, s));
            end
            checks++;
            if (frame_done !== (ph == 63)) begin
                errors++;
                $display("FAIL restart_frame_done ph=%0d got=%b expected=%b", ph, frame_done, (ph == 63));
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        logic [8:0] obs;
        while (ph < 116) tick();
        checks++;
        if ({A2, A1, A0, dec_en} !== {3'd6, 1'b1}) begin
            errors++;
            $display("FAIL areset_pre sel_en=%b expected=%b", {A2, A1, A0, dec_en}, {3'd6, 1'b1});
        end
        #2 rst_n = 1'b0;
        en = 1'b0;
        #1;
        obs = {A2, A1, A0, dec_en, digit_data, frame_done};
        checks++;
        if (obs !== 9'd0) begin
            errors++;
            $display("FAIL areset_immediate outputs=%b expected=%b", obs, 9'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1;
        tick();
        ph = 0;
        while (ph < 16) begin
            checks++;
            if (digit_data !== 4'd0) begin
                errors++;
                $display("FAIL areset_buffer ph=%0d got=%h expected=%h", ph, digit_data, 4'd0);
            end
            checks++;
            if ({A2, A1, A0, dec_en} !== {3'(ph / 8), (ph % 8 >= BLANK)}) begin
                errors++;
                $display("FAIL areset_rescan ph=%0d got=%b expected=%b", ph,
                         {A2, A1, A0, dec_en}, {3'(ph / 8), (ph % 8 >= BLANK)});
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_double_buffer();
        test_write_on_commit();
        test_enable_drop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
